hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Parametrised scoreboard for hazard detection and operand forwarding. It replaces the fixed two-flag hazard scheme with a general unit supporting DEPTH downstream stages. It tracks every in-flight register write behind decode, selects the youngest ready producer for each source operand, and stalls decode when a producer's result is not yet available. It also handles system halt and branch flush, and counts stall cycles for performance monitoring.

## Interface
- DEPTH, 3: tracked stages after decode; entries 1..DEPTH, entry 1 is youngest.
- DATA_W, 32: operand width.
- RADDR_W, 4: register address width.
- ALU_LAT, 1: an ALU result is forwardable from entry ALU_LAT onward.
- LOAD_LAT, 2: a load result is forwardable from entry LOAD_LAT onward; LOAD_LAT ≥ ALU_LAT, both ≤ DEPTH.
- ZERO_REG, 1: when 1, address 0 never matches and never stalls.
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- id_valid  in  1  decode holds a valid instruction.
- id_rs1, id_rs2  in  RADDR_W  source addresses.
- id_rs1_used, id_rs2_used  in  1  the corresponding source is read.
- id_rd  in  RADDR_W  destination address.
- id_wr  in  1  the instruction writes id_rd.
- id_load  in  1  the instruction is a load.
- stage_data  in  DEPTH*DATA_W  result of entry k in slice [(k-1)*DATA_W +: DATA_W].
- halt  in  1  freeze all state.
- flush  in  1  squash the instruction in decode.
- stall  out  1  decode must hold.
- issue  out  1  the decode instruction enters entry 1 this cycle.
- fwd1_sel, fwd2_sel  out  $clog2(DEPTH+1)  forwarding source: 0 = register file, k = entry k.
- fwd1_data, fwd2_data  out  DATA_W  stage_data of the selected entry; 0 when sel = 0.
- stall_cnt  out  16  saturating count of stall cycles.

## Operation
- Each entry holds {valid, wr, load, rd}.
- Matching:
  - Source s matches entry k when s_used is set, entry k is valid with wr set, rd equals s, and s ≠ 0 or ZERO_REG = 0.
  - Only the lowest-index (youngest) matching entry counts.
- Readiness: a matching entry k is ready when k ≥ (load ? LOAD_LAT : ALU_LAT).
- Forwarding:
  - Ready match: sel = k and data = the stage_data slice for entry k.
  - No match: sel = 0 and data = 0.
  - Unready match: sel = 0 as well.
- stall = id_valid & !flush & (either used source has an unready youngest match).
  - An older ready match is never used to bypass a younger unready one.
- issue = id_valid & !stall & !flush & !halt.
- Shift on each edge with rst high and halt low:
  - Entry k+1 takes entry k.
  - Entry 1 takes the decode fields when issue is set, otherwise a bubble (valid = 0).
  - Entry DEPTH retires.
- Halt:
  - halt high freezes every entry and stall_cnt.
  - Halt has priority over flush; a flush during halt has no effect.
  - stall, fwd and issue outputs stay combinational; issue is forced to 0.
- stall_cnt increments on cycles where stall = 1 and halt = 0, and saturates at 16'hFFFF.
- Reset: while rst is low at an edge, all entries are cleared to invalid and stall_cnt is set to 0. This includes reset mid-operation; in-flight writers are discarded. Consequently the outputs after reset are stall = 0, issue = id_valid & !flush & !halt, sel = 0, data = 0, and stall_cnt = 0.

## Timing
- stall, issue, fwd*_sel and fwd*_data are combinational from the inputs and current entries in the same cycle. There are no registers on the output path.
- An instruction accepted at edge N sits in entry 1 during cycle N+1 and in entry k during cycle N+k.
- Load-use dependence on the next instruction: with LOAD_LAT = 2 and ALU_LAT = 1 this costs LOAD_LAT − ALU_LAT = 1 stall cycle. Generally, a dependent instruction k entries behind a load stalls max(0, LOAD_LAT − k) cycles.
- ALU-to-ALU dependence costs 0 stalls when ALU_LAT = 1.
- stall_cnt is updated one edge after the stalled cycle.

## Test plan
- Reset with rst = 0 for 2 cycles while issuing → all outputs 0 except issue (follows the formula), stall_cnt = 0; no entry is valid after release.
- ALU write r3 followed by an ALU read of r3 → next cycle fwd1_sel = 1, fwd1_data = stage_data slice 0, stall = 0.
- Load r5 followed by a read of r5 → 1 cycle with stall = 1 and issue = 0; next cycle fwd sel = 2; stall_cnt = 1.
- r2 written at entries 1 (ALU) and 3 (load), then r2 is read → fwd sel = 1; the younger producer wins.
- halt raised for 4 cycles during a stall → entries and stall_cnt frozen; flush ignored; the sequence resumes identically after halt drops.
- Read of r0 with ZERO_REG = 1 while r0 is pending → sel = 0, stall = 0. stall_cnt driven by 70000 stall cycles → reads 16'hFFFF.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Scoreboard of in-flight writers behind decode: picks the youngest ready producer per source, else stalls.
// Outputs are combinational from decode fields and entries; entries shift each edge unless halted.
module hazard_fwd_unit #(
  parameter int DEPTH    = 3,
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 4,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [RADDR_W-1:0]        id_rs1,
  input  logic [RADDR_W-1:0]        id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [RADDR_W-1:0]        id_rd,
  input  logic                      id_wr,
  input  logic                      id_load,
  input  logic [DEPTH*DATA_W-1:0]   stage_data,
  input  logic                      halt,
  input  logic                      flush,
  output logic                      stall,
  output logic                      issue,
  output logic [SEL_W-1:0]          fwd1_sel,
  output logic [SEL_W-1:0]          fwd2_sel,
  output logic [DATA_W-1:0]         fwd1_data,
  output logic [DATA_W-1:0]         fwd2_data,
  output logic [15:0]               stall_cnt
);

  typedef struct packed {
    logic               valid;
    logic               wr;
    logic               load;
    logic [RADDR_W-1:0] rd;
  } entry_t;

  entry_t      ent_q [1:DEPTH];
  entry_t      ent_d [1:DEPTH];
  logic [15:0] cnt_q, cnt_d;
  logic        hit1, hit2, rdy1, rdy2;

  function automatic logic src_match(input logic used, input logic [RADDR_W-1:0] src,
                                     input entry_t e);
    return used && e.valid && e.wr && (e.rd == src) && ((src != '0) || !ZERO_REG);
  endfunction

  function automatic logic is_ready(input int k, input logic load);
    return k >= (load ? LOAD_LAT : ALU_LAT);
  endfunction

  // Scan oldest to youngest so the youngest match overwrites any older one.
  always_comb begin
    hit1      = 1'b0;
    rdy1      = 1'b0;
    hit2      = 1'b0;
    rdy2      = 1'b0;
    fwd1_sel  = '0;
    fwd2_sel  = '0;
    fwd1_data = '0;
    fwd2_data = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (src_match(id_rs1_used, id_rs1, ent_q[k])) begin
        hit1      = 1'b1;
        rdy1      = is_ready(k, ent_q[k].load);
        fwd1_sel  = rdy1 ? SEL_W'(k) : '0;
        fwd1_data = rdy1 ? stage_data[(k-1)*DATA_W +: DATA_W] : '0;
      end
      if (src_match(id_rs2_used, id_rs2, ent_q[k])) begin
        hit2      = 1'b1;
        rdy2      = is_ready(k, ent_q[k].load);
        fwd2_sel  = rdy2 ? SEL_W'(k) : '0;
        fwd2_data = rdy2 ? stage_data[(k-1)*DATA_W +: DATA_W] : '0;
      end
    end
  end

  assign stall     = id_valid && !flush && ((hit1 && !rdy1) || (hit2 && !rdy2));
  assign issue     = id_valid && !stall && !flush && !halt;
  assign stall_cnt = cnt_q;

  always_comb begin
    ent_d[1] = issue ? entry_t'({1'b1, id_wr, id_load, id_rd}) : entry_t'('0);
    for (int k = 2; k <= DEPTH; k++) begin
      ent_d[k] = ent_q[k-1];
    end
    cnt_d = (stall && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        ent_q[k] <= '0;
      end
      cnt_q <= '0;
    end else if (!halt) begin
      for (int k = 1; k <= DEPTH; k++) begin
        ent_q[k] <= ent_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: default instance for forwarding/stall/halt/reset,
// plus a deep high-latency instance that stalls 15 of every 16 cycles to reach counter saturation.
module tb_hazard_fwd_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, id_rs1_used, id_rs2_used, id_wr, id_load, halt, flush;
  logic [3:0]  id_rs1, id_rs2, id_rd;
  logic [95:0] stage_data;
  logic        stall, issue;
  logic [1:0]  fwd1_sel, fwd2_sel;
  logic [31:0] fwd1_data, fwd2_data;
  logic [15:0] stall_cnt;

  logic         s_rst;
  logic [127:0] s_stage_data;
  logic         s_stall, s_issue;
  logic [4:0]   s_sel1, s_sel2;
  logic [7:0]   s_d1, s_d2;
  logic [15:0]  s_cnt;

  int n_chk = 0;
  int n_err = 0;

  hazard_fwd_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .stage_data(stage_data), .halt(halt), .flush(flush),
    .stall(stall), .issue(issue), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data), .stall_cnt(stall_cnt)
  );

  // Self-dependent writer that only becomes forwardable at the last of 16 entries.
  hazard_fwd_unit #(.DEPTH(16), .DATA_W(8), .ALU_LAT(16), .LOAD_LAT(16)) sat (
    .clk(clk), .rst(s_rst), .id_valid(1'b1), .id_rs1(4'd1), .id_rs2(4'd0),
    .id_rs1_used(1'b1), .id_rs2_used(1'b0), .id_rd(4'd1), .id_wr(1'b1),
    .id_load(1'b0), .stage_data(s_stage_data), .halt(1'b0), .flush(1'b0),
    .stall(s_stall), .issue(s_issue), .fwd1_sel(s_sel1), .fwd2_sel(s_sel2),
    .fwd1_data(s_d1), .fwd2_data(s_d2), .stall_cnt(s_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] rs1, input logic u1,
                       input logic [3:0] rs2, input logic u2,
                       input logic [3:0] rd, input logic wr, input logic ld);
    id_valid = v;  id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd;    id_wr = wr;   id_load = ld;
    #1;
  endtask

  initial begin
    stage_data   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    s_stage_data = '0;
    rst = 1'b0; s_rst = 1'b0; halt = 1'b0; flush = 1'b0;

    // Reset held two edges while decode tries to issue a writer.
    drive(1, 4'd3, 1, 4'd0, 0, 4'd3, 1, 0);
    tick();
    check("rst_stall", stall, 0);
    check("rst_issue", issue, 1);
    check("rst_sel1", fwd1_sel, 0);
    check("rst_data1", fwd1_data, 0);
    check("rst_cnt", stall_cnt, 0);
    tick();
    check("rst2_cnt", stall_cnt, 0);
    rst = 1'b1;
    drive(1, 4'd3, 1, 4'd3, 1, 4'd0, 0, 0);
    check("post_rst_sel1", fwd1_sel, 0);
    check("post_rst_sel2", fwd2_sel, 0);
    check("post_rst_stall", stall, 0);

    // ALU r3 then ALU read of r3.
    drive(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 0);
    check("alu_issue", issue, 1);
    tick();
    drive(1, 4'd3, 1, 4'd3, 0, 4'd0, 0, 0);
    check("alu_sel1", fwd1_sel, 1);
    check("alu_data1", fwd1_data, 32'h1111_1111);
    check("alu_stall", stall, 0);
    check("alu_sel2_unused", fwd2_sel, 0);
    tick();

    // Load r5 then read r5 (and r3, now in entry 3).
    drive(1, 4'd0, 0, 4'd0, 0, 4'd5, 1, 1);
    tick();
    drive(1, 4'd5, 1, 4'd3, 1, 4'd0, 0, 0);
    check("ld_stall", stall, 1);
    check("ld_issue", issue, 0);
    check("ld_sel1", fwd1_sel, 0);
    check("ld_data1", fwd1_data, 0);
    check("ld_sel2", fwd2_sel, 3);
    check("ld_data2", fwd2_data, 32'h3333_3333);
    check("ld_cnt0", stall_cnt, 0);
    tick();
    check("ld2_stall", stall, 0);
    check("ld2_issue", issue, 1);
    check("ld2_sel1", fwd1_sel, 2);
    check("ld2_data1", fwd1_data, 32'h2222_2222);
    check("ld2_sel2_retired", fwd2_sel, 0);
    check("ld2_cnt", stall_cnt, 1);
    tick();

    // r2: load at entry 3, ALU at entry 1.
    drive(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 1);
    tick();
    drive(1, 4'd0, 0, 4'd0, 0, 4'd9, 1, 0);
    tick();
    drive(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 0);
    tick();
    drive(1, 4'd2, 1, 4'd2, 1, 4'd0, 0, 0);
    check("young_sel1", fwd1_sel, 1);
    check("young_data1", fwd1_data, 32'h1111_1111);
    check("young_sel2", fwd2_sel, 1);
    check("young_stall", stall, 0);

    // ALU r7 older, load r7 younger: the unready load must stall.
    drive(1, 4'd0, 0, 4'd0, 0, 4'd7, 1, 0);
    tick();
    drive(1, 4'd0, 0, 4'd0, 0, 4'd7, 1, 1);
    tick();
    drive(1, 4'd7, 1, 4'd0, 0, 4'd0, 0, 0);
    check("nobypass_stall", stall, 1);
    check("nobypass_sel1", fwd1_sel, 0);
    check("nobypass_issue", issue, 0);
    check("pre_halt_cnt", stall_cnt, 1);

    // Halt for four edges during the stall, with flush pulsed and a non-dependent decode.
    halt = 1'b1;
    #1;
    check("halt_issue", issue, 0);
    check("halt_stall", stall, 1);
    tick();
    check("halt1_cnt", stall_cnt, 1);
    check("halt1_stall", stall, 1);
    flush = 1'b1;
    #1;
    check("halt_flush_stall", stall, 0);
    check("halt_flush_issue", issue, 0);
    tick();
    tick();
    check("halt3_cnt", stall_cnt, 1);
    flush = 1'b0;
    drive(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0);
    check("halt_free_stall", stall, 0);
    check("halt_free_issue", issue, 0);
    tick();
    halt = 1'b0;
    drive(1, 4'd7, 1, 4'd0, 0, 4'd0, 0, 0);
    check("resume_stall", stall, 1);
    check("resume_sel1", fwd1_sel, 0);
    check("resume_cnt", stall_cnt, 1);
    tick();
    check("resume2_stall", stall, 0);
    check("resume2_issue", issue, 1);
    check("resume2_sel1", fwd1_sel, 2);
    check("resume2_data1", fwd1_data, 32'h2222_2222);
    check("resume2_cnt", stall_cnt, 2);
    tick();

    // r0 pending as a load never matches.
    drive(1, 4'd0, 0, 4'd0, 0, 4'd0, 1, 1);
    tick();
    drive(1, 4'd0, 1, 4'd0, 1, 4'd0, 0, 0);
    check("r0_stall", stall, 0);
    check("r0_sel1", fwd1_sel, 0);
    check("r0_sel2", fwd2_sel, 0);
    check("r0_issue", issue, 1);
    tick();

    // Flush masks a stall; reset mid-operation discards the pending load.
    drive(1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 1);
    tick();
    flush = 1'b1;
    drive(1, 4'd4, 1, 4'd0, 0, 4'd0, 0, 0);
    check("flush_stall", stall, 0);
    check("flush_issue", issue, 0);
    flush = 1'b0;
    #1;
    check("unflush_stall", stall, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_stall", stall, 0);
    check("midrst_issue", issue, 1);
    check("midrst_cnt", stall_cnt, 0);

    // Saturation: 15 stalls per 16 edges, 75000 edges in total.
    s_rst = 1'b1;
    for (int e = 1; e <= 75000; e++) begin
      tick();
      if (e == 32)    check("sat_cnt_32", s_cnt, 30);
      if (e == 69888) check("sat_cnt_69888", s_cnt, 65520);
      if (e == 69904) check("sat_cnt_69904", s_cnt, 16'hFFFF);
    end
    check("sat_cnt_end", s_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
